// File: rtl/fir_pkg.sv
// Shared constants and state type for the FIR MAC sequencer.
// Enable windows and drain length are derived from the datapath pipeline latencies.
package fir_pkg;

    localparam int NUM_TAPS = 10;
    localparam int TAP_W    = 4;
    localparam int COEF_W   = 16;

    localparam int RD_LAT  = 1;
    localparam int MUL_LAT = 1;
    localparam int ACC_LAT = 1;

    // Delay from a coefficient read to the matching multiply / add enable.
    localparam int MUL_DLY = RD_LAT;
    localparam int ADD_DLY = RD_LAT + MUL_LAT;

    // Cycles between the last tap read and the output-valid cycle.
    localparam int DRAIN_LEN = ADD_DLY + ACC_LAT - 1;
    localparam int DRAIN_W   = $clog2(DRAIN_LEN + 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        RUN,
        DRAIN,
        DONE
    } seqState_t;

endpackage

// File: rtl/fir_enable_pipe.sv
// Delays the per-tap read flags into the multiplier and accumulator enables so that
// each enable lines up with the data it acts on.
module fir_enable_pipe
    import fir_pkg::*;
(
    input  logic iClk,
    input  logic iRsn,
    input  logic iRun,
    input  logic iFirst,
    output logic oEnMul,
    output logic oEnAdd,
    output logic oEnAcc
);

    logic [ADD_DLY-1:0] runSr;
    logic [ADD_DLY-1:0] accSr;

    // accSr carries "accumulate" for every tap but the first, which loads instead.
    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            runSr <= '0;
            accSr <= '0;
        end else begin
            runSr <= {runSr[ADD_DLY-2:0], iRun};
            accSr <= {accSr[ADD_DLY-2:0], iRun & ~iFirst};
        end
    end

    assign oEnMul = runSr[MUL_DLY-1];
    assign oEnAdd = runSr[ADD_DLY-1];
    assign oEnAcc = accSr[ADD_DLY-1];

endmodule

// File: rtl/fir_mac_sequencer.sv
// Sequencer for the 10-tap FIR MAC datapath: shifts the delay chain, walks the taps,
// times the MAC enables and arbitrates the coefficient RAM against host writes.
//
// state | meaning
// IDLE  | waiting for a sample strobe; host writes may be granted
// SHIFT | delay-chain shift pulse
// RUN   | one tap per cycle: coefficient read, tap select
// DRAIN | waiting for multiplier/accumulator pipeline to empty
// DONE  | accumulator output valid
module fir_mac_sequencer
    import fir_pkg::*;
(
    input  logic              iClk12M,
    input  logic              iRsn,
    input  logic              iEnable,
    input  logic              iSampleStb,
    input  logic              iCoeffWrReq,
    input  logic [TAP_W-1:0]  iCoeffWrAddr,
    input  logic [COEF_W-1:0] iCoeffWrData,
    input  logic              iClrErr,
    output logic              oShift,
    output logic [TAP_W-1:0]  oCoeffAddr,
    output logic              oCoeffRd,
    output logic              oCoeffWe,
    output logic [COEF_W-1:0] oCoeffWdata,
    output logic [TAP_W-1:0]  oTapSel,
    output logic              oEnMul,
    output logic              oEnAdd,
    output logic              oEnAcc,
    output logic              oOutValid,
    output logic              oBusy,
    output logic              oCoeffWrAck,
    output logic              oOverrun
);

    seqState_t          state, nextState;
    logic [TAP_W-1:0]   tapCnt, nextTap;
    logic [DRAIN_W-1:0] drainCnt, nextDrain;
    logic               sampleAccept;
    logic               overrunSet;
    logic               wrArmed;
    logic               wrGrant;
    logic               wrInRange;
    logic               firstTap;

    assign sampleAccept = (state == IDLE) && iSampleStb && iEnable;
    assign overrunSet   = (state != IDLE) && iSampleStb && iEnable;
    // The sample strobe always wins the RAM; a held request must drop before re-grant.
    assign wrGrant      = (state == IDLE) && !sampleAccept && iCoeffWrReq && wrArmed;
    assign wrInRange    = iCoeffWrAddr < TAP_W'(NUM_TAPS);

    always_comb begin
        nextState = state;
        nextTap   = '0;
        nextDrain = drainCnt;
        case (state)
            IDLE: begin
                if (sampleAccept) nextState = SHIFT;
            end
            SHIFT: begin
                nextState = RUN;
            end
            RUN: begin
                if (tapCnt == TAP_W'(NUM_TAPS - 1)) begin
                    nextState = DRAIN;
                    nextDrain = DRAIN_W'(DRAIN_LEN - 1);
                end else begin
                    nextTap = tapCnt + 1'b1;
                end
            end
            DRAIN: begin
                if (drainCnt == '0) nextState = DONE;
                else                nextDrain = drainCnt - 1'b1;
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            state    <= IDLE;
            tapCnt   <= '0;
            drainCnt <= '0;
        end else begin
            state    <= nextState;
            tapCnt   <= nextTap;
            drainCnt <= nextDrain;
        end
    end

    // Outputs are registered from the next-state decode so they align with the state.
    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            oShift      <= 1'b0;
            oBusy       <= 1'b0;
            oCoeffRd    <= 1'b0;
            oTapSel     <= '0;
            oOutValid   <= 1'b0;
            oCoeffAddr  <= '0;
            oCoeffWe    <= 1'b0;
            oCoeffWrAck <= 1'b0;
            oCoeffWdata <= '0;
        end else begin
            oShift      <= (nextState == SHIFT);
            oBusy       <= (nextState != IDLE);
            oCoeffRd    <= (nextState == RUN);
            oTapSel     <= nextTap;
            oOutValid   <= (nextState == DONE);
            oCoeffAddr  <= wrGrant ? iCoeffWrAddr : nextTap;
            oCoeffWe    <= wrGrant && wrInRange;
            oCoeffWrAck <= wrGrant;
            if (wrGrant) oCoeffWdata <= iCoeffWrData;
        end
    end

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            wrArmed  <= 1'b1;
            oOverrun <= 1'b0;
        end else begin
            if (wrGrant)           wrArmed <= 1'b0;
            else if (!iCoeffWrReq) wrArmed <= 1'b1;
            oOverrun <= overrunSet || (oOverrun && !iClrErr);
        end
    end

    assign firstTap = oCoeffRd && (oTapSel == '0);

    fir_enable_pipe uEnablePipe (
        .iClk   (iClk12M),
        .iRsn   (iRsn),
        .iRun   (oCoeffRd),
        .iFirst (firstTap),
        .oEnMul (oEnMul),
        .oEnAdd (oEnAdd),
        .oEnAcc (oEnAcc)
    );

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: per-cycle timeline checks plus a small MAC datapath
// driven by the sequencer outputs, compared against a direct dot-product reference.
`timescale 1ns/1ps
module tb_fir_mac_sequencer;
    import fir_pkg::*;

    logic              iClk12M = 1'b0;
    logic              iRsn = 1'b1;
    logic              iEnable = 1'b0;
    logic              iSampleStb = 1'b0;
    logic              iCoeffWrReq = 1'b0;
    logic [TAP_W-1:0]  iCoeffWrAddr = '0;
    logic [COEF_W-1:0] iCoeffWrData = '0;
    logic              iClrErr = 1'b0;
    logic              oShift, oCoeffRd, oCoeffWe, oEnMul, oEnAdd, oEnAcc;
    logic              oOutValid, oBusy, oCoeffWrAck, oOverrun;
    logic [TAP_W-1:0]  oCoeffAddr, oTapSel;
    logic [COEF_W-1:0] oCoeffWdata;

    fir_mac_sequencer dut (
        .iClk12M      (iClk12M),
        .iRsn         (iRsn),
        .iEnable      (iEnable),
        .iSampleStb   (iSampleStb),
        .iCoeffWrReq  (iCoeffWrReq),
        .iCoeffWrAddr (iCoeffWrAddr),
        .iCoeffWrData (iCoeffWrData),
        .iClrErr      (iClrErr),
        .oShift       (oShift),
        .oCoeffAddr   (oCoeffAddr),
        .oCoeffRd     (oCoeffRd),
        .oCoeffWe     (oCoeffWe),
        .oCoeffWdata  (oCoeffWdata),
        .oTapSel      (oTapSel),
        .oEnMul       (oEnMul),
        .oEnAdd       (oEnAdd),
        .oEnAcc       (oEnAcc),
        .oOutValid    (oOutValid),
        .oBusy        (oBusy),
        .oCoeffWrAck  (oCoeffWrAck),
        .oOverrun     (oOverrun)
    );

    always #42 iClk12M = ~iClk12M;

    int nChecks = 0;
    int nErrors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Datapath driven purely by the sequencer outputs.
    logic [COEF_W-1:0] ramModel [16];
    logic [15:0]       dly [NUM_TAPS];
    logic [15:0]       sampleIn = '0;
    logic [15:0]       ramQ, tapQ;
    logic [31:0]       prod;
    logic [63:0]       acc;

    always @(posedge iClk12M) begin
        if (oCoeffWe) ramModel[oCoeffAddr] <= oCoeffWdata;
        if (oShift) begin
            dly[0] <= sampleIn;
            for (int i = 1; i < NUM_TAPS; i++) dly[i] <= dly[i-1];
        end
        if (oCoeffRd) begin
            ramQ <= ramModel[oCoeffAddr];
            tapQ <= dly[oTapSel];
        end
        if (oEnMul) prod <= ramQ * tapQ;
        if (oEnAdd) acc <= oEnAcc ? acc + 64'(prod) : 64'(prod);
    end

    // Reference: coefficient table and sample history, newest first.
    logic [15:0] refCoef [NUM_TAPS];
    logic [15:0] hist [$];

    function automatic longint refSum();
        longint s = 0;
        for (int k = 0; k < NUM_TAPS; k++)
            if (k < hist.size()) s += longint'(refCoef[k]) * longint'(hist[k]);
        return s;
    endfunction

    function automatic logic [16:0] ctl();
        return {oShift, oBusy, oCoeffRd, oCoeffWe, oEnMul, oEnAdd, oEnAcc, oOutValid,
                oCoeffWrAck, oCoeffAddr, oTapSel};
    endfunction

    function automatic logic [33:0] allOut();
        return {ctl(), oOverrun, oCoeffWdata};
    endfunction

    // Expected controls for cycle n after the accepting edge.
    function automatic logic [16:0] expCtl(input int n);
        logic       rd;
        logic [3:0] a;
        rd = (n >= 2) && (n <= 11);
        a  = rd ? 4'(n - 2) : 4'd0;
        return {n == 1, (n >= 1) && (n <= 14), rd, 1'b0, (n >= 3) && (n <= 12),
                (n >= 4) && (n <= 13), (n >= 5) && (n <= 13), n == 14, 1'b0, a, a};
    endfunction

    task automatic tick();
        @(posedge iClk12M);
        #1;
    endtask

    task automatic pushSample(input logic [15:0] v);
        hist.push_front(v);
        if (hist.size() > NUM_TAPS) void'(hist.pop_back());
    endtask

    task automatic runSample(input logic [15:0] val, input int ovrCyc, input bit clr);
        sampleIn   = val;
        iEnable    = 1'b1;
        iSampleStb = 1'b1;
        tick();
        iSampleStb = 1'b0;
        pushSample(val);
        for (int n = 1; n <= 15; n++) begin
            chk($sformatf("seq c%0d", n), 64'(ctl()), 64'(expCtl(n)));
            if (n == 14) chk("mac", acc, 64'(refSum()));
            iSampleStb = (n == ovrCyc);
            iClrErr    = (n == ovrCyc) && clr;
            if (n < 15) tick();
        end
        iSampleStb = 1'b0;
        iClrErr    = 1'b0;
    endtask

    task automatic checkAck(input logic [TAP_W-1:0] addr, input logic [15:0] data);
        chk("ack", 64'({oCoeffWrAck, oCoeffWe, oCoeffRd, oCoeffAddr}),
            64'({1'b1, addr < 4'(NUM_TAPS), 1'b0, addr}));
        chk("wdata", 64'(oCoeffWdata), 64'(data));
        if (addr < 4'(NUM_TAPS)) refCoef[int'(addr)] = data;
    endtask

    task automatic hostWrite(input logic [TAP_W-1:0] addr, input logic [15:0] data, input bit hold);
        iCoeffWrReq  = 1'b1;
        iCoeffWrAddr = addr;
        iCoeffWrData = data;
        tick();
        checkAck(addr, data);
        if (hold) begin
            tick();
            chk("noregrant", 64'(oCoeffWrAck), 64'(0));
        end
        iCoeffWrReq = 1'b0;
        tick();
        chk("ackdrop", 64'({oCoeffWrAck, oCoeffWe}), 64'(0));
    endtask

    initial begin
        int nv;
        logic [15:0] d;
        for (int i = 0; i < 16; i++) ramModel[i] = '0;
        for (int i = 0; i < NUM_TAPS; i++) begin
            dly[i] = '0;
            refCoef[i] = '0;
        end

        #5 iRsn = 1'b0;
        #200;
        chk("reset", 64'(allOut()), 64'(0));
        @(negedge iClk12M) iRsn = 1'b1;
        tick();

        hostWrite(4'd3, 16'h1234, 1'b0);
        hostWrite(4'd12, 16'hBEEF, 1'b1);
        for (int k = 0; k < NUM_TAPS; k++) hostWrite(4'(k), 16'd1, 1'b0);

        for (int v = 1; v <= 10; v++) runSample(16'(v), 0, 1'b0);
        chk("sum55", acc, 64'd55);
        runSample(16'd11, 0, 1'b0);
        chk("sum65", acc, 64'd65);

        chk("ovr idle", 64'(oOverrun), 64'(0));
        runSample(16'($urandom), 6, 1'b0);
        chk("ovr set", 64'(oOverrun), 64'(1));
        tick();
        chk("ovr sticky", 64'(oOverrun), 64'(1));
        iClrErr = 1'b1;
        tick();
        iClrErr = 1'b0;
        chk("ovr clr", 64'(oOverrun), 64'(0));
        runSample(16'($urandom), 5, 1'b1);
        chk("ovr setwins", 64'(oOverrun), 64'(1));
        iClrErr = 1'b1;
        tick();
        iClrErr = 1'b0;
        runSample(16'($urandom), 14, 1'b0);
        chk("ovr done", 64'(oOverrun), 64'(1));
        iClrErr = 1'b1;
        tick();
        iClrErr = 1'b0;
        chk("ovr clr2", 64'(oOverrun), 64'(0));

        // Write request colliding with a strobe waits for the sequence to finish.
        d = 16'($urandom);
        iCoeffWrReq  = 1'b1;
        iCoeffWrAddr = 4'd5;
        iCoeffWrData = d;
        runSample(16'($urandom), 0, 1'b0);
        tick();
        checkAck(4'd5, d);
        iCoeffWrReq = 1'b0;
        // Strobe in the ack cycle is accepted.
        runSample(16'($urandom), 0, 1'b0);

        repeat (16) begin
            case ($urandom_range(0, 3))
                0: hostWrite(4'($urandom_range(0, 15)), 16'($urandom), 1'($urandom_range(0, 1)));
                3: begin
                    iEnable    = 1'b0;
                    iSampleStb = 1'b1;
                    tick();
                    iSampleStb = 1'b0;
                    chk("disabled", 64'({oBusy, oShift, oOverrun}), 64'(0));
                    iEnable = 1'b1;
                end
                default: runSample(16'($urandom), 0, 1'b0);
            endcase
        end

        // Asynchronous reset in cycle 8 of a sequence.
        sampleIn   = 16'($urandom);
        iSampleStb = 1'b1;
        tick();
        iSampleStb = 1'b0;
        pushSample(sampleIn);
        repeat (7) tick();
        chk("pre rst busy", 64'(oBusy), 64'(1));
        #10 iRsn = 1'b0;
        #1 chk("async rst", 64'(allOut()), 64'(0));
        #20 iRsn = 1'b1;
        nv = 0;
        repeat (20) begin
            tick();
            nv += int'(oOutValid) + int'(oBusy);
        end
        chk("quiet after rst", 64'(nv), 64'(0));
        iEnable    = 1'b0;
        iSampleStb = 1'b1;
        tick();
        iSampleStb = 1'b0;
        chk("dis after rst", 64'({oBusy, oShift, oOverrun}), 64'(0));
        runSample(16'($urandom), 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
- Controller for the 10-tap FIR MAC datapath (multiplier, then accumulator).
- On each input-sample strobe it shifts the delay chain, then walks the taps one per cycle by driving the coefficient-RAM address and tap select.
- It times the multiplier and accumulator enables against the pipeline latency and flags the finished output.
- It also arbitrates the single-port coefficient RAM between the MAC sequence and a host write port.

Parameters:
- NUM_TAPS, 10, taps per output sample.
- TAP_W, 4, width of tap index and coefficient address.
- COEF_W, 16, coefficient data width.

Ports:
- iClk12M  input  1  clock, rising edge.
- iRsn  input  1  asynchronous active-low reset.
- iEnable  input  1  level; 0 blocks acceptance of new sample strobes.
- iSampleStb  input  1  one-cycle pulse: new input sample available.
- iCoeffWrReq  input  1  host write request; held until ack.
- iCoeffWrAddr  input  TAP_W  host write address; stable while req.
- iCoeffWrData  input  COEF_W  host write data; stable while req.
- iClrErr  input  1  clears oOverrun.
- oShift  output  1  delay-chain shift pulse.
- oCoeffAddr  output  TAP_W  coefficient RAM address.
- oCoeffRd  output  1  coefficient RAM read enable.
- oCoeffWe  output  1  coefficient RAM write enable.
- oCoeffWdata  output  COEF_W  coefficient RAM write data.
- oTapSel  output  TAP_W  delay-tap select, aligned with oCoeffAddr.
- oEnMul  output  1  multiplier enable.
- oEnAdd  output  1  accumulator add enable.
- oEnAcc  output  1  accumulator accumulate (1) / load (0).
- oOutValid  output  1  one-cycle pulse: accumulator output valid.
- oBusy  output  1  sequence in progress.
- oCoeffWrAck  output  1  one-cycle grant/ack for host write.
- oOverrun  output  1  sticky: strobe arrived while busy.

Behaviour:
- Reset: all outputs registered and reset to 0; FSM to IDLE; tap counter to 0. Reset mid-sequence aborts it with no oOutValid.
- FSM states: IDLE, SHIFT, RUN, DRAIN, DONE.
- IDLE -> SHIFT when iSampleStb=1 and iEnable=1. This is edge E0; cycle n means n cycles after E0.
- Cycle 1 (SHIFT): oShift=1, oBusy=1.
- Cycles 2..11 (RUN): oCoeffRd=1, oCoeffAddr=oTapSel=k for k=0..9.
- Latency alignment: RAM read latency 1; multiplier registered 1; accumulator registered 1.
  - oEnMul=1 in cycles 3..12.
  - oEnAdd=1 in cycles 4..13.
  - oEnAcc=0 in cycle 4 (load first product, discarding the previous sum); oEnAcc=1 in cycles 5..13.
- DRAIN covers cycles 12..13.
- Cycle 14 (DONE): oOutValid=1, oBusy=1. Next cycle: IDLE, oBusy=0.
- Total 14 cycles per sample (budget at 12 MHz / 48 kHz is 250).
- iSampleStb while oBusy=1, or in SHIFT: the strobe is ignored, the sequence continues unchanged, and oOverrun is set.
- iSampleStb with iEnable=0: ignored, no error.
- iEnable dropping mid-sequence: the current sequence completes normally.
- oOverrun clears on iClrErr=1. Set wins if set and clear occur in the same cycle.
- Host write arbitration:
  - Granted only in IDLE when iSampleStb is not being accepted in the same cycle; the sample strobe has priority.
  - On grant (next cycle): oCoeffWrAck=1, oCoeffWe=1, oCoeffAddr=iCoeffWrAddr, oCoeffWdata=iCoeffWrData, all for one cycle.
  - The FSM stays IDLE during a write. A sample strobe arriving in the ack cycle is accepted normally.
  - After ack the requester must drop req. If req is still high in the ack cycle it is not re-granted; it needs a 0 -> 1 edge.
  - Write address >= NUM_TAPS: acked, but oCoeffWe stays 0.
- oCoeffRd and oCoeffWe are never both 1.
- Outside the active windows, oCoeffAddr/oTapSel hold 0 and oCoeffWdata holds its last value.

Decomposition:
- Shared package fir_pkg holds:
  - NUM_TAPS, TAP_W, COEF_W.
  - FSM state enum.
  - Pipeline latency constants RD_LAT=1, MUL_LAT=1, ACC_LAT=1, from which the enable windows are derived.
- One sub-module is natural: fir_enable_pipe, a small shift register that delays the RUN/first-tap flags into oEnMul/oEnAdd/oEnAcc. The FSM, tap counter and write arbiter stay in the top.

Test Plan:
- Single strobe, iEnable=1, after reset -> oShift at cycle 1; addr 0..9 in cycles 2..11; oEnMul 3..12; oEnAdd 4..13; oEnAcc=0 only at cycle 4; oOutValid at cycle 14 only; oBusy=0 at cycle 15.
- Coefficients all 1 and taps 1..10 in the datapath model -> oMac=55 sampled when oOutValid=1. A second strobe with taps shifted yields the sum excluding the old value (load works).
- Strobe at cycle 6 of a sequence -> sequence unchanged, oOverrun=1 and stays 1; iClrErr pulse -> 0; simultaneous strobe-while-busy and clear -> stays 1.
- Host write req (addr 3, data 0x1234) in IDLE -> ack next cycle with oCoeffWe=1, addr 3, data 0x1234. Req with addr 12 -> ack with oCoeffWe=0.
- Write req and sample strobe asserted in the same IDLE cycle -> sample accepted, no ack during the 14-cycle sequence, ack the cycle after return to IDLE. oCoeffRd&oCoeffWe never 1.
- iRsn asserted at cycle 8 asynchronously -> all outputs 0 immediately. After release, no oOutValid until a new strobe; iEnable=0 strobe -> no response, no overrun.
